frame1024_to_1020_sync: RTL and testbench
=========================================

// Module: frame1024_to_1020_sync
// PURPOSE
//  Receive-side deframer for the serial marker-framed link. Consumes a bit stream of frames
//  (32-bit marker 0xAA550100 MSB-first, then BYTES_IN_FRAME payload bytes) and hunts for marker
//  alignment. It confirms lock over several frames, then strips the marker and forwards only
//  payload bits with frame-start strobes. Sits directly downstream of Frame1020_to_1024 (link side).
// PARAMETERS
//  BYTES_IN_FRAME  1020          payload bytes per frame; sims use 32
//  MARKER          32'hAA550100  sync word, first received bit = MARKER[31]
//  LOCK_CONFIRM    2             consecutive exact markers (incl. first hit) needed for LOCK, >=2
//  LOSS_THRESHOLD  3             consecutive bad markers in LOCK that drop to HUNT, >=1
//  MAX_MARKER_ERR  0             bit errors tolerated in marker while LOCKED, 0..31
// PORTS
//  CLK          in   1  single clock, all logic on rising edge
//  RST          in   1  synchronous reset, active-high
//  IN           in   1  serial data bit, sampled when VALID_IN=1
//  VALID_IN     in   1  IN qualifier; gaps are allowed, and the block stalls on VALID_IN=0
//  OUT          out  1  payload bit (registered)
//  VALID_OUT    out  1  OUT qualifier; high only for payload bits while LOCKED
//  FRAME_START  out  1  one-cycle pulse coincident with the first payload bit of each frame
//  LOCKED       out  1  state==LOCK
//  MARKER_ERR   out  1  one-cycle pulse: marker check in LOCK exceeded MAX_MARKER_ERR
// BEHAVIOUR
//  - Constants: FRAME_BITS=8*(BYTES_IN_FRAME+4), PAYLOAD_BITS=8*BYTES_IN_FRAME.
//    cnt is $clog2(FRAME_BITS) bits wide. win = {sreg[30:0],IN} is the current 32-bit window.
//  - Reset: all outputs 0, sreg=0, cnt=0, hits=0, misses=0, state=HUNT. RST wins over VALID_IN.
//    Reset mid-frame discards the partial frame, and the next edge after release starts the hunt.
//  - VALID_IN=0: no state, cnt, or sreg change; VALID_OUT=0 and FRAME_START=0 next cycle.
//  - On VALID_IN=1: sreg<=win. In VERIFY/LOCK, cnt advances 0..FRAME_BITS-1, then wraps to 0.
//    cnt 0..PAYLOAD_BITS-1 = payload bits. cnt FRAME_BITS-1 = last marker bit (check point).
//  - errs = popcount(win ^ MARKER), evaluated only at the check point (HUNT: every valid bit).
//  - HUNT: win==MARKER -> VERIFY, cnt<=0, hits<=1. Otherwise stay. No output.
//  - VERIFY: at check point, errs==0 -> hits+1; if hits+1==LOCK_CONFIRM -> LOCK, misses<=0.
//    errs!=0 -> HUNT. sreg is kept, so the hunt resumes on the next valid bit. No output.
//  - LOCK: at check point, errs<=MAX_MARKER_ERR -> misses<=0.
//    Otherwise MARKER_ERR pulse and misses+1. If misses+1==LOSS_THRESHOLD -> HUNT, LOCKED<=0.
//    Else alignment is flywheeled, frame boundary unchanged, and the payload is still forwarded.
//  - Output (LOCK only): OUT<=IN, VALID_OUT<=1 when VALID_IN and cnt<PAYLOAD_BITS.
//    FRAME_START<=1 when additionally cnt==0. Latency IN->OUT = 1 cycle.
//  - The first payload forwarded is the frame following the LOCK_CONFIRM-th marker.
//    Frames received during VERIFY are dropped.
//  - Simultaneous loss-of-lock and check point: VALID_OUT is already 0 at the check point (marker bit).
//    No payload is emitted after the transition to HUNT.
//  - LOCKED updates on the same edge as the state register. MARKER_ERR and FRAME_START never
//    assert outside LOCK.
// STRUCTURE
//  - Shared header frame_link_defs.vh: MARKER value, FRAME_BITS/PAYLOAD_BITS formulas,
//    state encodings ST_HUNT=2'd0, ST_VERIFY=2'd1, ST_LOCK=2'd2.
//    Shared with the transmit framer.
//  - Sub-module marker_err_count: combinational 32-bit XOR + popcount -> 6-bit errs.
//  - Top: sreg, cnt, hits/misses counters, 3-state FSM, output registers.
// TESTING (BYTES_IN_FRAME=32, FRAME_BITS=288, defaults otherwise)
//  1. 3 frames with marker AA550100 after 17 random bits, VALID_IN=1 throughout.
//     -> LOCKED rises at the 2nd marker check. Frame 3 payload appears on OUT 1 cycle late.
//     -> 256 VALID_OUT bits, FRAME_START on the first one.
//  2. Pseudo-marker AA550100 inside HUNT, then 2nd marker position corrupted (0xAA550101).
//     -> back to HUNT, no VALID_OUT. Later true markers lock normally.
//  3. Locked, corrupt 2 consecutive markers -> 2 MARKER_ERR pulses, LOCKED stays 1.
//     -> payload of the following frames is still forwarded.
//     A 3rd bad marker -> LOCKED=0, no further VALID_OUT.
//  4. Locked, VALID_IN toggled 1010 pattern mid-payload -> OUT/VALID_OUT follow with 1-cycle latency.
//     -> bit count per frame stays 256, FRAME_START spacing = 288 valid bits.
//  5. RST=1 for 1 cycle at payload bit 100 of a locked frame -> all outputs 0 the next cycle.
//     -> state HUNT, relock requires 2 fresh markers.
//  6. MAX_MARKER_ERR=1 build: marker with 1 flipped bit while locked -> no MARKER_ERR.
//     -> 2 flipped bits -> MARKER_ERR pulse.

Source files
------------

// File: rtl/frame1024_to_1020_sync_pkg.sv
// Shared link definitions for the marker-framed serial link (receive and transmit sides).
// Provides the sync marker value, frame/payload bit-count helpers and the deframer
// state type. The state values match the legacy encodings (HUNT=0, VERIFY=1, LOCK=2).
package frame1024_to_1020_sync_pkg;

  localparam logic [31:0] LINK_MARKER = 32'hAA550100;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } sync_state_e;

  // Frame = 4 marker bytes followed by the payload bytes.
  function automatic int unsigned frame_bits(input int unsigned bytes_in_frame);
    return 8 * (bytes_in_frame + 4);
  endfunction

  function automatic int unsigned payload_bits(input int unsigned bytes_in_frame);
    return 8 * bytes_in_frame;
  endfunction

endpackage

// File: rtl/frame1024_to_1020_sync_marker_err_count.sv
// marker_err_count: number of bit positions in which the 32-bit receive window differs
// from the sync marker (XOR followed by popcount). Purely combinational.
// Ports:
//   i_win    [31:0]  current 32-bit receive window
//   i_marker [31:0]  reference sync marker
//   o_errs   [5:0]   mismatching bit count, 0..32
module marker_err_count
  import frame1024_to_1020_sync_pkg::*;
(
  input  logic [31:0] i_win,
  input  logic [31:0] i_marker,
  output logic [5:0]  o_errs
);

  logic [31:0] w_diff;

  assign w_diff = i_win ^ i_marker;

  always_comb begin
    o_errs = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      o_errs = o_errs + 6'(w_diff[i]);
    end
  end

endmodule

// File: rtl/frame1024_to_1020_sync.sv
// frame1024_to_1020_sync: receive-side deframer. Hunts for the 32-bit sync marker in a
// serial bit stream, confirms alignment over LOCK_CONFIRM exact markers, then strips
// the marker and forwards only payload bits with a frame-start strobe. While locked,
// bad markers are flywheeled until LOSS_THRESHOLD consecutive misses drop back to hunt.
// Ports:
//   CLK          clock, rising edge
//   RST          synchronous reset, active-high (wins over VALID_IN)
//   IN           serial data bit, sampled when VALID_IN=1
//   VALID_IN     IN qualifier; block stalls while low
//   OUT          registered payload bit
//   VALID_OUT    OUT qualifier, payload bits while locked only
//   FRAME_START  pulse with the first payload bit of each frame
//   LOCKED       high while in LOCK
//   MARKER_ERR   pulse when a locked marker check exceeds MAX_MARKER_ERR
module frame1024_to_1020_sync
  import frame1024_to_1020_sync_pkg::*;
#(
  parameter int unsigned BYTES_IN_FRAME = 1020,
  parameter logic [31:0] MARKER         = LINK_MARKER,
  parameter int unsigned LOCK_CONFIRM   = 2,
  parameter int unsigned LOSS_THRESHOLD = 3,
  parameter int unsigned MAX_MARKER_ERR = 0
) (
  input  logic CLK,
  input  logic RST,
  input  logic IN,
  input  logic VALID_IN,
  output logic OUT,
  output logic VALID_OUT,
  output logic FRAME_START,
  output logic LOCKED,
  output logic MARKER_ERR
);

  localparam int unsigned FRAME_BITS   = frame_bits(BYTES_IN_FRAME);
  localparam int unsigned PAYLOAD_BITS = payload_bits(BYTES_IN_FRAME);
  localparam int unsigned CW           = $clog2(FRAME_BITS);
  localparam int unsigned HW           = $clog2(LOCK_CONFIRM + 1);
  localparam int unsigned MW           = $clog2(LOSS_THRESHOLD + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] CNT_PAY  = CW'(PAYLOAD_BITS);
  localparam logic [HW-1:0] HITS_REQ = HW'(LOCK_CONFIRM);
  localparam logic [MW-1:0] MISS_MAX = MW'(LOSS_THRESHOLD);
  localparam logic [5:0]    ERR_MAX  = 6'(MAX_MARKER_ERR);

  sync_state_e   r_state;
  logic [31:0]   r_sreg;
  logic [CW-1:0] r_cnt;
  logic [HW-1:0] r_hits;
  logic [MW-1:0] r_miss;
  logic          r_out;
  logic          r_vo;
  logic          r_fs;
  logic          r_locked;
  logic          r_me;

  logic [31:0]   w_win;
  logic [5:0]    w_errs;
  logic          w_check;
  logic [CW-1:0] w_cnt_next;
  logic [HW-1:0] w_hits_inc;
  logic [MW-1:0] w_miss_inc;

  assign w_win      = {r_sreg[30:0], IN};
  assign w_check    = (r_cnt == CNT_LAST);
  assign w_cnt_next = w_check ? '0 : r_cnt + 1'b1;
  assign w_hits_inc = r_hits + 1'b1;
  assign w_miss_inc = r_miss + 1'b1;

  marker_err_count u_err (
    .i_win    (w_win),
    .i_marker (MARKER),
    .o_errs   (w_errs)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_HUNT;
      r_sreg   <= '0;
      r_cnt    <= '0;
      r_hits   <= '0;
      r_miss   <= '0;
      r_out    <= 1'b0;
      r_vo     <= 1'b0;
      r_fs     <= 1'b0;
      r_locked <= 1'b0;
      r_me     <= 1'b0;
    end else begin
      // Strobes are single-cycle; only a valid bit in LOCK can re-raise them.
      r_vo <= 1'b0;
      r_fs <= 1'b0;
      r_me <= 1'b0;
      if (VALID_IN) begin
        r_sreg <= w_win;
        case (r_state)
          ST_HUNT: begin
            if (w_errs == '0) begin
              r_state <= ST_VERIFY;
              r_cnt   <= '0;
              r_hits  <= HW'(1);
            end
          end
          ST_VERIFY: begin
            r_cnt <= w_cnt_next;
            if (w_check) begin
              if (w_errs == '0) begin
                r_hits <= w_hits_inc;
                if (w_hits_inc == HITS_REQ) begin
                  r_state  <= ST_LOCK;
                  r_locked <= 1'b1;
                  r_miss   <= '0;
                end
              end else begin
                // sreg already holds the shifted window, so hunting continues seamlessly.
                r_state <= ST_HUNT;
              end
            end
          end
          ST_LOCK: begin
            r_cnt <= w_cnt_next;
            if (r_cnt < CNT_PAY) begin
              r_out <= IN;
              r_vo  <= 1'b1;
              r_fs  <= (r_cnt == '0);
            end
            if (w_check) begin
              if (w_errs <= ERR_MAX) begin
                r_miss <= '0;
              end else begin
                r_me <= 1'b1;
                if (w_miss_inc == MISS_MAX) begin
                  r_state  <= ST_HUNT;
                  r_locked <= 1'b0;
                  r_miss   <= '0;
                end else begin
                  r_miss <= w_miss_inc;
                end
              end
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign OUT         = r_out;
  assign VALID_OUT   = r_vo;
  assign FRAME_START = r_fs;
  assign LOCKED      = r_locked;
  assign MARKER_ERR  = r_me;

endmodule

// File: tb/tb_frame1024_to_1020_sync.sv
// Bench for frame1024_to_1020_sync: two instances share one input stream, one with the
// default marker tolerance (0) and one with MAX_MARKER_ERR=1. A bit-serial reference model
// (history window, position-in-frame integer, confirm/miss counts) predicts every output.
module tb_frame1024_to_1020_sync;

  localparam int BYTES = 32;
  localparam int FB    = 8 * (BYTES + 4);
  localparam int PB    = 8 * BYTES;
  localparam int LC    = 2;
  localparam int LT    = 3;
  localparam logic [31:0] MK = 32'hAA550100;

  logic CLK = 1'b0;
  logic RST, IN, VALID_IN;
  logic d_out[2], d_vo[2], d_fs[2], d_lk[2], d_me[2];

  always #5 CLK = ~CLK;

  frame1024_to_1020_sync #(
    .BYTES_IN_FRAME (BYTES),
    .MARKER         (MK),
    .LOCK_CONFIRM   (LC),
    .LOSS_THRESHOLD (LT),
    .MAX_MARKER_ERR (0)
  ) u_dut0 (
    .CLK(CLK), .RST(RST), .IN(IN), .VALID_IN(VALID_IN),
    .OUT(d_out[0]), .VALID_OUT(d_vo[0]), .FRAME_START(d_fs[0]),
    .LOCKED(d_lk[0]), .MARKER_ERR(d_me[0])
  );

  frame1024_to_1020_sync #(
    .BYTES_IN_FRAME (BYTES),
    .MARKER         (MK),
    .LOCK_CONFIRM   (LC),
    .LOSS_THRESHOLD (LT),
    .MAX_MARKER_ERR (1)
  ) u_dut1 (
    .CLK(CLK), .RST(RST), .IN(IN), .VALID_IN(VALID_IN),
    .OUT(d_out[1]), .VALID_OUT(d_vo[1]), .FRAME_START(d_fs[1]),
    .LOCKED(d_lk[1]), .MARKER_ERR(d_me[1])
  );

  // Reference model state, one slot per instance.
  logic [31:0] m_win[2];
  int          m_pos[2];   // bit index within frame, -1 while searching
  int          m_conf[2];
  int          m_miss[2];
  bit          m_lock[2];
  bit          e_out[2], e_vo[2], e_fs[2], e_me[2];
  int          maxerr[2];

  int n_chk  = 0;
  int n_fail = 0;
  int t_vo[2], t_fs[2], t_me[2];
  int vin_cnt = 0;
  int last_fs_at = -1;
  int fs_gap = 0;
  bit gap_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int k, input bit in, input bit v, input bit rst);
    logic [31:0] w;
    int idx;
    int bad;
    if (rst) begin
      m_win[k] = '0; m_pos[k] = -1; m_conf[k] = 0; m_miss[k] = 0; m_lock[k] = 0;
      e_out[k] = 0; e_vo[k] = 0; e_fs[k] = 0; e_me[k] = 0;
      return;
    end
    e_vo[k] = 0; e_fs[k] = 0; e_me[k] = 0;
    if (!v) return;
    w = {m_win[k][30:0], in};
    m_win[k] = w;
    if (m_pos[k] < 0) begin
      if (w == MK) begin
        m_pos[k]  = 0;
        m_conf[k] = 1;
      end
      return;
    end
    idx = m_pos[k];
    m_pos[k] = (idx + 1) % FB;
    if (m_lock[k] && idx < PB) begin
      e_out[k] = in;
      e_vo[k]  = 1;
      e_fs[k]  = (idx == 0);
    end
    if (idx == FB - 1) begin
      bad = $countones(w ^ MK);
      if (!m_lock[k]) begin
        if (bad == 0) begin
          m_conf[k]++;
          if (m_conf[k] == LC) begin
            m_lock[k] = 1;
            m_miss[k] = 0;
          end
        end else begin
          m_pos[k] = -1;
        end
      end else if (bad <= maxerr[k]) begin
        m_miss[k] = 0;
      end else begin
        e_me[k] = 1;
        m_miss[k]++;
        if (m_miss[k] == LT) begin
          m_lock[k] = 0;
          m_pos[k]  = -1;
        end
      end
    end
  endtask

  task automatic step(input bit in, input bit v, input bit rst);
    IN = in; VALID_IN = v; RST = rst;
    @(posedge CLK);
    for (int k = 0; k < 2; k++) model(k, in, v, rst);
    if (v && !rst) vin_cnt++;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("vo%0d", k),  32'(d_vo[k]),  32'(e_vo[k]));
      chk($sformatf("out%0d", k), 32'(d_out[k]), 32'(e_out[k]));
      chk($sformatf("fs%0d", k),  32'(d_fs[k]),  32'(e_fs[k]));
      chk($sformatf("lk%0d", k),  32'(d_lk[k]),  32'(m_lock[k]));
      chk($sformatf("me%0d", k),  32'(d_me[k]),  32'(e_me[k]));
      t_vo[k] += int'(d_vo[k]);
      t_fs[k] += int'(d_fs[k]);
      t_me[k] += int'(d_me[k]);
    end
    if (d_fs[0]) begin
      if (last_fs_at >= 0) fs_gap = vin_cnt - last_fs_at;
      last_fs_at = vin_cnt;
    end
  endtask

  task automatic send_bit(input bit b);
    step(b, 1'b1, 1'b0);
    if (gap_mode) step(1'($urandom), 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
  endtask

  task automatic frame(input logic [31:0] m);
    send_word(m);
    send_rand(PB);
  endtask

  task automatic clear_tallies();
    for (int k = 0; k < 2; k++) begin
      t_vo[k] = 0; t_fs[k] = 0; t_me[k] = 0;
    end
  endtask

  initial begin
    maxerr[0] = 0;
    maxerr[1] = 1;
    for (int k = 0; k < 2; k++) model(k, 1'b0, 1'b0, 1'b1);
    clear_tallies();

    // Reset state
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_vo", 32'(d_vo[0]), 32'd0);
    chk("rst_lk", 32'(d_lk[0]), 32'd0);

    // 1: random lead-in, three good frames; only the third payload is forwarded
    clear_tallies();
    send_rand(17);
    frame(MK);
    send_word(MK);
    chk("t1_lock_at_2nd", 32'(d_lk[0]), 32'd1);
    chk("t1_no_verify_out", 32'(t_vo[0]), 32'd0);
    send_rand(PB);
    send_word(MK);
    chk("t1_vo_count", 32'(t_vo[0]), 32'(PB));
    chk("t1_fs_count", 32'(t_fs[0]), 32'd1);

    // 2: pseudo-marker then corrupted second marker, then true relock
    step(1'b0, 1'b1, 1'b1);
    clear_tallies();
    send_rand(10);
    frame(MK);
    frame(32'hAA550101);
    chk("t2_not_locked", 32'(d_lk[0]), 32'd0);
    chk("t2_no_vo", 32'(t_vo[0] + t_vo[1]), 32'd0);
    frame(MK);
    frame(MK);
    send_word(MK);
    chk("t2_relock_vo", 32'(t_vo[0]), 32'(PB));
    chk("t2_relocked", 32'(d_lk[0]), 32'd1);

    // 3: flywheel through two bad markers, third drops lock
    clear_tallies();
    send_rand(PB);
    send_word(MK ^ 32'h3);
    send_rand(PB);
    send_word(MK ^ 32'h3);
    chk("t3_me_two", 32'(t_me[0]), 32'd2);
    chk("t3_still_locked", 32'(d_lk[0]), 32'd1);
    send_rand(PB);
    send_word(MK ^ 32'h3);
    chk("t3_vo_flywheel", 32'(t_vo[0]), 32'(3 * PB));
    chk("t3_lost", 32'(d_lk[0]), 32'd0);
    chk("t3_me_three_dut1", 32'(t_me[1]), 32'd3);
    clear_tallies();
    send_rand(PB);
    send_word(32'h12345678);
    chk("t3_no_vo_after_loss", 32'(t_vo[0]), 32'd0);

    // 4: gapped input (1010 valid pattern) while locked
    step(1'b0, 1'b1, 1'b1);
    send_rand(5);
    frame(MK);
    frame(MK);
    send_word(MK);
    gap_mode = 1;
    clear_tallies();
    last_fs_at = -1;
    fs_gap = 0;
    send_rand(PB);
    send_word(MK);
    chk("t4_vo_gapped", 32'(t_vo[0]), 32'(PB));
    chk("t4_fs_gapped", 32'(t_fs[0]), 32'd1);
    send_rand(PB);
    send_word(MK);
    chk("t4_fs_spacing", 32'(fs_gap), 32'(FB));
    chk("t4_vo_two", 32'(t_vo[0]), 32'(2 * PB));
    gap_mode = 0;

    // 5: reset at payload bit 100 of a locked frame
    send_rand(100);
    step(1'($urandom), 1'b1, 1'b1);
    chk("t5_vo", 32'(d_vo[0]), 32'd0);
    chk("t5_out", 32'(d_out[0]), 32'd0);
    chk("t5_fs", 32'(d_fs[0]), 32'd0);
    chk("t5_lk", 32'(d_lk[0]), 32'd0);
    chk("t5_me", 32'(d_me[0]), 32'd0);
    clear_tallies();
    send_rand(PB - 101);
    frame(MK);
    send_word(MK);
    chk("t5_dropped_verify", 32'(t_vo[0]), 32'd0);
    chk("t5_relocked", 32'(d_lk[0]), 32'd1);
    send_rand(PB);
    send_word(MK);
    chk("t5_vo_after", 32'(t_vo[0]), 32'(PB));

    // 6: one-bit and two-bit marker errors against both tolerances
    send_rand(PB);
    clear_tallies();
    send_word(MK ^ 32'h0000_0400);
    chk("t6_1bit_me0", 32'(t_me[0]), 32'd1);
    chk("t6_1bit_me1", 32'(t_me[1]), 32'd0);
    send_rand(PB);
    send_word(MK ^ 32'h8001_0000);
    chk("t6_2bit_me0", 32'(t_me[0]), 32'd2);
    chk("t6_2bit_me1", 32'(t_me[1]), 32'd1);
    send_rand(PB);
    send_word(MK);
    chk("t6_lk0", 32'(d_lk[0]), 32'd1);
    chk("t6_lk1", 32'(d_lk[1]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
